// File: rtl/auto_test_pkg.sv
// Shared constants, channel encoding and expected readback pattern for the
// auto-test readback checker.
package auto_test_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int ECNT_W_DEF = 16;

    localparam logic [3:0] PAT_HI = 4'hA;
    localparam logic [3:0] PAT_LO = 4'h5;

    typedef enum logic {
        CH_DAQ = 1'b0,
        CH_TRG = 1'b1
    } chan_e;

    function automatic logic [15:0] exp_pattern(input logic [3:0] addr);
        return {PAT_HI, addr, ~addr, PAT_LO};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating counter with synchronous clear; rd optionally shows the value
// including this cycle's increment so a clearing reader never loses it.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         inc,
    input  logic         byp_rd,
    output logic [W-1:0] rd
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_inc;

    assign cnt_inc = (inc && !(&cnt)) ? cnt + W'(1) : cnt;
    assign rd      = byp_rd ? cnt_inc : cnt;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/auto_test_rbk_checker.sv
// Readback checker: owns the address pointer, compares readback words against
// the test pattern and publishes per-pass word-error counts on UPDATE.
module auto_test_rbk_checker
    import auto_test_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ECNT_W = ECNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR_ADDR,
    input  logic              INCR,
    input  logic              DAQ_CHK,
    input  logic              TRG_CHK,
    input  logic              UPDATE,
    input  logic              TEST_ACTIVE,
    input  logic [15:0]       RBK_DATA,
    output logic [ADDR_W-1:0] RBK_ADDR,
    output logic [ECNT_W-1:0] DAQ_ERRS,
    output logic [ECNT_W-1:0] TRG_ERRS,
    output logic              DAQ_FAIL,
    output logic              TRG_FAIL,
    output logic [ADDR_W-1:0] FIRST_ERR_ADDR,
    output logic              FIRST_ERR_VLD,
    output logic [ECNT_W-1:0] TEST_CNT,
    output logic              UPD_DONE
);

    logic              pass_sel;
    chan_e             sel_chan;
    logic              cmp_en;
    logic              upd_en;
    logic              pend_vld;
    logic              pend_mis;
    chan_e             pend_chan;
    logic [ADDR_W-1:0] pend_addr;
    logic              err_hit;
    logic [ECNT_W-1:0] daq_rd;
    logic [ECNT_W-1:0] trg_rd;

    assign pass_sel = DAQ_CHK | TRG_CHK;
    assign sel_chan = TRG_CHK ? CH_TRG : CH_DAQ;
    assign cmp_en   = INCR & pass_sel & TEST_ACTIVE;
    assign upd_en   = UPDATE & pass_sel & TEST_ACTIVE;
    assign err_hit  = pend_vld & pend_mis;

    // NOTE: a working counter clears on its own UPDATE while the bypassed read
    // already folds in the stage-1 increment landing in that same cycle.
    sat_counter #(.W(ECNT_W)) u_daq_work (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (~TEST_ACTIVE | (upd_en & (sel_chan == CH_DAQ))),
        .inc    (err_hit & (pend_chan == CH_DAQ)),
        .byp_rd (1'b1),
        .rd     (daq_rd)
    );

    sat_counter #(.W(ECNT_W)) u_trg_work (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (~TEST_ACTIVE | (upd_en & (sel_chan == CH_TRG))),
        .inc    (err_hit & (pend_chan == CH_TRG)),
        .byp_rd (1'b1),
        .rd     (trg_rd)
    );

    sat_counter #(.W(ECNT_W)) u_test_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (1'b0),
        .inc    (upd_en),
        .byp_rd (1'b0),
        .rd     (TEST_CNT)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            RBK_ADDR       <= '0;
            pend_vld       <= 1'b0;
            pend_mis       <= 1'b0;
            pend_chan      <= CH_DAQ;
            pend_addr      <= '0;
            FIRST_ERR_ADDR <= '0;
            FIRST_ERR_VLD  <= 1'b0;
            DAQ_ERRS       <= '0;
            TRG_ERRS       <= '0;
            DAQ_FAIL       <= 1'b0;
            TRG_FAIL       <= 1'b0;
            UPD_DONE       <= 1'b0;
        end else begin
            if (CLR_ADDR) begin
                RBK_ADDR <= '0;
            end else if (INCR) begin
                RBK_ADDR <= RBK_ADDR + ADDR_W'(1);
            end

            // Compare uses the pre-increment address.
            pend_vld <= cmp_en;
            if (cmp_en) begin
                pend_mis  <= (RBK_DATA != exp_pattern(4'(RBK_ADDR)));
                pend_chan <= sel_chan;
                pend_addr <= RBK_ADDR;
            end

            if (!TEST_ACTIVE) begin
                FIRST_ERR_VLD <= 1'b0;
            end else if (err_hit && !FIRST_ERR_VLD) begin
                FIRST_ERR_VLD  <= 1'b1;
                FIRST_ERR_ADDR <= pend_addr;
            end

            UPD_DONE <= upd_en;
            if (upd_en) begin
                if (sel_chan == CH_TRG) begin
                    TRG_ERRS <= trg_rd;
                    TRG_FAIL <= |trg_rd;
                end else begin
                    DAQ_ERRS <= daq_rd;
                    DAQ_FAIL <= |daq_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_auto_test_rbk_checker.sv
// Self-checking bench for auto_test_rbk_checker: directed test-plan steps plus
// a randomized phase, all compared against a transaction-level reference model.
module tb_auto_test_rbk_checker;

    localparam int MAXC = 65535;

    logic        CLK = 1'b0;
    logic        RST, CLR_ADDR, INCR, DAQ_CHK, TRG_CHK, UPDATE, TEST_ACTIVE;
    logic [15:0] RBK_DATA;
    logic [3:0]  RBK_ADDR, FIRST_ERR_ADDR;
    logic [15:0] DAQ_ERRS, TRG_ERRS, TEST_CNT;
    logic        DAQ_FAIL, TRG_FAIL, FIRST_ERR_VLD, UPD_DONE;

    int checks = 0;
    int errors = 0;

    auto_test_rbk_checker dut (
        .CLK            (CLK),
        .RST            (RST),
        .CLR_ADDR       (CLR_ADDR),
        .INCR           (INCR),
        .DAQ_CHK        (DAQ_CHK),
        .TRG_CHK        (TRG_CHK),
        .UPDATE         (UPDATE),
        .TEST_ACTIVE    (TEST_ACTIVE),
        .RBK_DATA       (RBK_DATA),
        .RBK_ADDR       (RBK_ADDR),
        .DAQ_ERRS       (DAQ_ERRS),
        .TRG_ERRS       (TRG_ERRS),
        .DAQ_FAIL       (DAQ_FAIL),
        .TRG_FAIL       (TRG_FAIL),
        .FIRST_ERR_ADDR (FIRST_ERR_ADDR),
        .FIRST_ERR_VLD  (FIRST_ERR_VLD),
        .TEST_CNT       (TEST_CNT),
        .UPD_DONE       (UPD_DONE)
    );

    always #5 CLK = ~CLK;

    // Reference model: a queue of outstanding compare results plus plain integers.
    typedef struct {
        bit trg;
        int addr;
        bit mis;
    } cmp_t;

    cmp_t pend_q[$];
    int m_addr, m_wd, m_wt, m_pd, m_pt, m_fea, m_tc;
    bit m_fev, m_ud;

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic [15:0] exp_word(input int a);
        int n;
        n = a % 16;
        return 16'(32'hA005 + n * 256 + (15 - n) * 16);
    endfunction

    task automatic model_reset();
        pend_q.delete();
        m_addr = 0; m_wd = 0; m_wt = 0; m_pd = 0; m_pt = 0;
        m_fea = 0; m_tc = 0; m_fev = 0; m_ud = 0;
    endtask

    task automatic model_tick();
        cmp_t e;
        bit   hit;
        int   ed, et;
        if (RST) begin
            model_reset();
            return;
        end
        hit = 0;
        if (pend_q.size() > 0) begin
            e   = pend_q.pop_front();
            hit = e.mis;
        end
        ed = sat(m_wd + ((hit && !e.trg) ? 1 : 0));
        et = sat(m_wt + ((hit && e.trg) ? 1 : 0));
        m_ud = 0;
        if (!TEST_ACTIVE) begin
            m_wd = 0; m_wt = 0; m_fev = 0;
            pend_q.delete();
        end else begin
            if (hit && !m_fev) begin
                m_fev = 1;
                m_fea = e.addr;
            end
            m_wd = ed;
            m_wt = et;
            if (UPDATE && (DAQ_CHK || TRG_CHK)) begin
                if (TRG_CHK) begin m_pt = et; m_wt = 0; end
                else         begin m_pd = ed; m_wd = 0; end
                m_tc = sat(m_tc + 1);
                m_ud = 1;
            end
            if (INCR && (DAQ_CHK || TRG_CHK))
                pend_q.push_back('{TRG_CHK, m_addr, RBK_DATA != exp_word(m_addr)});
        end
        if (CLR_ADDR)  m_addr = 0;
        else if (INCR) m_addr = (m_addr + 1) % 16;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        check("rbk_addr",  32'(RBK_ADDR),       32'(m_addr));
        check("daq_errs",  32'(DAQ_ERRS),       32'(m_pd));
        check("trg_errs",  32'(TRG_ERRS),       32'(m_pt));
        check("daq_fail",  32'(DAQ_FAIL),       32'(m_pd != 0));
        check("trg_fail",  32'(TRG_FAIL),       32'(m_pt != 0));
        check("first_adr", 32'(FIRST_ERR_ADDR), 32'(m_fea));
        check("first_vld", 32'(FIRST_ERR_VLD),  32'(m_fev));
        check("test_cnt",  32'(TEST_CNT),       32'(m_tc));
        check("upd_done",  32'(UPD_DONE),       32'(m_ud));
    endtask

    // Drive inputs on the falling edge, model the rising edge, sample on the next fall.
    task automatic step(input bit rst, input bit clr, input bit incr, input bit daq,
                        input bit trg, input bit upd, input bit ta, input logic [15:0] data);
        RST = rst; CLR_ADDR = clr; INCR = incr; DAQ_CHK = daq; TRG_CHK = trg;
        UPDATE = upd; TEST_ACTIVE = ta; RBK_DATA = data;
        @(posedge CLK);
        model_tick();
        @(negedge CLK);
        check_all();
    endtask

    task automatic cmp(input bit trg, input bit bad);
        logic [15:0] d;
        d = exp_word(m_addr);
        if (bad) d = ~d;
        step(0, 0, 1, !trg, trg, 0, 1, d);
    endtask

    initial begin
        int pulses;
        RST = 1; CLR_ADDR = 0; INCR = 0; DAQ_CHK = 0; TRG_CHK = 0;
        UPDATE = 0; TEST_ACTIVE = 0; RBK_DATA = '0;
        model_reset();
        @(negedge CLK);

        // Reset and pointer sweep.
        step(1, 0, 0, 0, 0, 0, 0, 16'h0);
        check("rst_daq", 32'(DAQ_ERRS), 0);
        check("rst_tc",  32'(TEST_CNT), 0);
        step(0, 1, 0, 0, 0, 0, 1, 16'h0);
        check("clr_addr", 32'(RBK_ADDR), 0);
        for (int k = 1; k <= 17; k++) begin
            step(0, 0, 1, 0, 0, 0, 1, 16'h0);
            check("ptr_wrap", 32'(RBK_ADDR), 32'(k % 16));
        end
        step(0, 1, 1, 0, 0, 0, 1, 16'h0);
        check("clr_wins", 32'(RBK_ADDR), 0);

        // DAQ clean pass.
        for (int k = 0; k < 9; k++) cmp(0, 0);
        step(0, 0, 0, 1, 0, 1, 1, 16'h0);
        pulses = int'(UPD_DONE);
        check("daq_clean", 32'(DAQ_ERRS), 0);
        check("daq_nofail", 32'(DAQ_FAIL), 0);
        check("tc_one", 32'(TEST_CNT), 1);
        step(0, 0, 0, 0, 0, 0, 1, 16'h0);
        pulses += int'(UPD_DONE);
        check("upd_pulses", 32'(pulses), 1);

        // TRG pass with bad words at 3, 7 and the last compare (8).
        step(0, 1, 0, 0, 0, 0, 1, 16'h0);
        for (int k = 0; k < 9; k++) cmp(1, k == 3 || k == 7 || k == 8);
        step(0, 0, 0, 0, 1, 1, 1, 16'h0);
        check("trg_errs3", 32'(TRG_ERRS), 3);
        check("trg_fail",  32'(TRG_FAIL), 1);
        check("first3",    32'(FIRST_ERR_ADDR), 3);
        check("first_vld", 32'(FIRST_ERR_VLD), 1);

        // Flush by dropping TEST_ACTIVE for one cycle.
        cmp(0, 1);
        cmp(0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 16'h0);
        step(0, 0, 0, 1, 0, 1, 1, 16'h0);
        check("flush_daq", 32'(DAQ_ERRS), 0);
        check("flush_trg", 32'(TRG_ERRS), 3);
        check("flush_vld", 32'(FIRST_ERR_VLD), 0);

        // DAQ saturation.
        for (int k = 0; k < 65536 + 5; k++) cmp(0, 1);
        step(0, 0, 0, 1, 0, 1, 1, 16'h0);
        check("daq_sat", 32'(DAQ_ERRS), 32'hFFFF);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 2) == 0) ? 16'($urandom) : exp_word(m_addr);
            step(0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 19) != 0, d);
        end

        // Reset mid-pass with a mismatch in flight.
        cmp(0, 1);
        step(1, 0, 0, 0, 0, 0, 1, 16'h0);
        check("rst_mid_tc",  32'(TEST_CNT), 0);
        check("rst_mid_vld", 32'(FIRST_ERR_VLD), 0);
        step(0, 0, 0, 1, 0, 1, 1, 16'h0);
        check("rst_upd_daq", 32'(DAQ_ERRS), 0);
        check("rst_upd_tc",  32'(TEST_CNT), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
